// File: rtl/awgn_lzd_pkg.sv
// Shared helpers for the AWGN leading-zero detect / normalise path.
// Both the count width and the all-zero count code are derived from the operand width.
package awgn_lzd_pkg;

    function automatic int lzd_count_width(input int width);
        return $clog2(width);
    endfunction

    // An all-zero operand reports the all-ones count, as the old fixed-width LZD did.
    function automatic int lzd_zero_code(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/lzd_tree.sv
// Combinational leading-zero detector built as a pairwise valid/position tree.
// Each level halves the node count and prepends one bit to the position.
module lzd_tree
    import awgn_lzd_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int CW    = lzd_count_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero,
    output logic [CW-1:0]    lzc
);

    for (genvar l = 1; l <= CW; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [N-1:0]        v;
        logic [N-1:0][l-1:0] p;

        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 1) begin : g_leaf
                assign v[i] = data[2*i+1] | data[2*i];
                assign p[i] = ~data[2*i+1];
            end else begin : g_merge
                // The upper half wins when it holds a one; otherwise count past it into the lower half.
                logic hi_v;
                assign hi_v = g_lvl[l-1].v[2*i+1];
                assign v[i] = hi_v | g_lvl[l-1].v[2*i];
                assign p[i] = hi_v ? {1'b0, g_lvl[l-1].p[2*i+1]}
                                   : {1'b1, g_lvl[l-1].p[2*i]};
            end
        end
    end

    assign zero = ~g_lvl[CW].v[0];
    assign lzc  = g_lvl[CW].p[0];

endmodule

// File: rtl/lzd_norm_pipe.sv
// Three-stage pipelined leading-zero detector and normaliser with valid/ready flow control.
// Stages: capture, leading-zero count, left-justify; a tag rides along with each beat.
module lzd_norm_pipe
    import awgn_lzd_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  TAG_W = 4,
    localparam int CW    = lzd_count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_lzc,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("lzd_norm_pipe: WIDTH must be a power of two between 8 and 64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("lzd_norm_pipe: TAG_W must be at least 1");
    end

    logic             v1, v2, v3;
    logic             en1, en2, en3;
    logic [WIDTH-1:0] s1_data, s2_data;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [CW-1:0]    s2_lzc, tree_lzc;
    logic             s2_zero, tree_zero;

    // A stage may advance when it is empty or the stage after it is advancing.
    assign en3       = ~v3 | out_ready;
    assign en2       = ~v2 | en3;
    assign en1       = ~v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    lzd_tree #(.WIDTH(WIDTH)) u_tree (
        .data (s1_data),
        .zero (tree_zero),
        .lzc  (tree_lzc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_data <= '0;
            s1_tag  <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_tag  <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_data <= '0;
            s2_tag  <= '0;
            s2_lzc  <= '0;
            s2_zero <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s2_data <= s1_data;
                s2_tag  <= s1_tag;
                s2_lzc  <= tree_lzc;
                s2_zero <= tree_zero;
            end
        end
    end

    // Shifting a zero operand by the all-ones count still yields zero, so no special case is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_norm <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                out_norm <= s2_data << s2_lzc;
                out_lzc  <= s2_lzc;
                out_zero <= s2_zero;
                out_tag  <= s2_tag;
            end
        end
    end

endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
- Parametrised, pipelined leading-zero detector and normaliser for the AWGN datapath.
- Feeds the log/sqrt range-reduction stages with three outputs per beat:
  - the leading-zero count,
  - the left-justified (normalised) operand,
  - an all-zero flag.
- Generalises the fixed 32-bit combinational LZD to any power-of-two width, adds a registered 3-stage pipeline with valid/ready backpressure, and passes a user tag through alongside each beat.

Parameters:
- WIDTH, 32: operand width. Must be a power of two, 8..64; elaboration error otherwise.
- TAG_W, 4: sideband tag width, carried unchanged through the pipe. Minimum 1.
- CW, $clog2(WIDTH): count width (derived, localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_lzc  out  CW  number of leading zeros (MSB side).
- out_norm  out  WIDTH  in_data << out_lzc.
- out_zero  out  1  in_data was all zeros.
- out_tag  out  TAG_W  tag of this beat.

Behaviour:
- Transfer rules:
  - A transfer occurs when valid && ready on the same rising edge.
  - in_data/in_tag are sampled only on an input transfer.
- Pipeline stages, each with its own valid bit v1, v2, v3:
  - S1: register data and tag.
  - S2: LZD tree on the S1 data; register lzc, zero flag, data and tag.
  - S3: barrel-shift the data left by lzc; register norm, lzc, zero and tag. The S3 registers drive the outputs; out_valid = v3.
- Latency:
  - Exactly 3 cycles from input transfer to out_valid when not stalled.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Stage enables:
  - en3 = ~v3 | out_ready.
  - en2 = ~v2 | en3.
  - en1 = ~v1 | en2.
  - in_ready = en1. This is combinational from out_ready and the valid bits; it never depends on in_valid.
- Stage load:
  - When stage k is enabled, it loads the upstream valid bit and payload.
  - A bubble (upstream valid = 0) clears v_k.
  - Payload registers may load garbage when invalid; the bench checks outputs only while out_valid = 1.
- Stall:
  - While out_valid = 1 and out_ready = 0, all out_* signals hold stable.
  - No beat is lost or duplicated.
  - Once all three stages are full, in_ready = 0.
- Arithmetic:
  - lzc = index distance from bit WIDTH-1 to the highest set bit, range 0..WIDTH-1.
  - norm[WIDTH-1] = 1 whenever zero = 0.
- All-zero input:
  - zero = 1, lzc = WIDTH-1 (all-ones code, legacy-compatible), norm = 0.
  - This is the only case where norm[WIDTH-1] = 0.
- Single-bit inputs: input 1 gives lzc = WIDTH-1, zero = 0. It is distinguished from all-zero only by out_zero.
- Reset:
  - Asynchronous assert clears v1, v2 and v3, so out_valid = 0.
  - out_lzc = 0, out_norm = 0, out_zero = 0, out_tag = 0.
  - in_ready = 1 while reset is deasserted and the pipe is empty. During reset, in_ready is driven 1, but beats offered during reset are not captured.
  - Reset mid-stream discards all in-flight beats. The first beat after deassertion emerges 3 cycles after its transfer.
- Simultaneous events: input transfer and output transfer in the same cycle with a full pipe is legal and sustains full throughput.

Decomposition:
- Package awgn_lzd_pkg:
  - a function returning the count width for a given WIDTH;
  - the legacy all-zero count constant, used by both RTL and bench.
- Sub-module lzd_tree (combinational, generate-based): parametrised recursive pairwise valid/position tree producing {zero, lzc}, with log2(WIDTH) levels.
- The shifter and pipeline control stay in lzd_norm_pipe.

Test Plan:
- WIDTH=32, out_ready=1, single beat in_data=0x0000_0001, tag=3 -> exactly 3 cycles later out_lzc=31, out_norm=0x8000_0000, out_zero=0, out_tag=3.
- WIDTH=32, in_data=0x8000_0000, then 0x0001_2345 back-to-back -> consecutive outputs:
  - lzc=0, norm=0x8000_0000;
  - lzc=15, norm=0x91A2_8000.
- WIDTH=32, in_data=0 -> out_zero=1, out_lzc=31, out_norm=0.
- Backpressure:
  - Stream 8 random beats with out_ready=0 for cycles 4..9 -> in_ready drops after 3 accepted beats.
  - Outputs hold stable while stalled.
  - All 8 results emerge in order and match the model.
- Reset mid-stream: assert rst_n=0 while 3 beats are in flight -> out_valid=0 immediately, no stale beat after release.
  - The next beat appears 3 cycles after its transfer.
- WIDTH=64, TAG_W=1: sweep one-hot inputs for every bit position with random out_ready -> lzc = 63 - pos and norm = 1<<63 for every beat.
